// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the sequential ALU: opcode encoding,
//               FSM state encoding and a constant clog2 helper used to size
//               the shift-amount field and the multiply step counter.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcode field width; fixed, the encoding below fills it completely.
    localparam int OP_W = 3;

    // Opcodes 0-3 match the original 6-bit combinational ALU.
    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_SHL = 3'd5;
    localparam logic [OP_W-1:0] OP_SHR = 3'd6;
    localparam logic [OP_W-1:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Ceiling log2 for elaboration-time sizing; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_if
// Description : Issue/result handshake bundle for alu_seq.
//               master : operand issue side (drives in_valid/a/b/op and
//                        out_ready, observes in_ready and the result)
//               slave  : the ALU itself
//               Signals: in_valid, in_ready, a, b, op, out_valid, out_ready,
//                        result, flag_z, flag_n, flag_c, flag_v
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
    parameter int WIDTH = 6,
    parameter int OPW   = alu_pkg::OP_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
    );

endinterface : alu_seq_if
`default_nettype wire

// File: rtl/alu_comb.sv
`default_nettype none
// ============================================================================
// Module      : alu_comb
// Description : Single-cycle result and flag generation for opcodes 0-6.
//               MUL (7) is handled by the sequential datapath in alu_seq;
//               for that opcode the outputs here are zero and unused.
//               Ports: a, b, op in; result, flag_z/n/c/v out.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int OPW   = OP_W
) (
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    input  wire logic [OPW-1:0]   op,
    output logic      [WIDTH-1:0] result,
    output logic                  flag_z,
    output logic                  flag_n,
    output logic                  flag_c,
    output logic                  flag_v
);

    localparam int SHW = clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_sh;
    logic             w_sh_big;

    // Extra top bit carries out of ADD, and becomes the borrow for SUB.
    assign w_sum    = {1'b0, a} + {1'b0, b};
    assign w_diff   = {1'b0, a} - {1'b0, b};
    assign w_sh     = b[SHW-1:0];
    assign w_sh_big = ({{(32-SHW){1'b0}}, w_sh} >= 32'(WIDTH));

    always_comb begin
        result = '0;
        flag_c = 1'b0;
        flag_v = 1'b0;
        case (op)
            OP_ADD: begin
                result = w_sum[WIDTH-1:0];
                flag_c = w_sum[WIDTH];
                flag_v = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                result = w_diff[WIDTH-1:0];
                flag_c = w_diff[WIDTH];
                flag_v = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  result = w_sh_big ? '0 : (a << w_sh);
            OP_SHR:  result = w_sh_big ? '0 : (a >> w_sh);
            default: result = '0;
        endcase
    end

    assign flag_z = (result == '0);
    assign flag_n = result[MSB];

endmodule : alu_comb
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Registered ALU with valid/ready issue and result handshakes.
//               Non-MUL ops are registered at the accepting edge; MUL runs
//               a WIDTH-step shift-add loop followed by one finalise cycle.
//               One operation in flight; result held under backpressure.
//               Ports: clk, rst_n (async, active low), bus (alu_seq_if.slave)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int OPW   = OP_W
) (
    input  wire logic clk,
    input  wire logic rst_n,
    alu_seq_if.slave  bus
);

    localparam int CNTW = clog2(WIDTH + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH);

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_flag_z;
    logic               r_flag_n;
    logic               r_flag_c;
    logic               r_flag_v;

    // Shift-add multiplier: multiplicand shifts left through a 2*WIDTH
    // register so the full product is available for the overflow flag.
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNTW-1:0]    r_count;
    logic [2*WIDTH-1:0] w_acc_next;

    logic [WIDTH-1:0]   w_res;
    logic               w_z;
    logic               w_n;
    logic               w_c;
    logic               w_v;
    logic               w_accept;

    alu_comb #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_comb (
        .a      (bus.a),
        .b      (bus.b),
        .op     (bus.op),
        .result (w_res),
        .flag_z (w_z),
        .flag_n (w_n),
        .flag_c (w_c),
        .flag_v (w_v)
    );

    assign w_accept   = bus.in_valid && r_in_ready;
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flag_z    <= 1'b0;
            r_flag_n    <= 1'b0;
            r_flag_c    <= 1'b0;
            r_flag_v    <= 1'b0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_count     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // in_ready comes up on the first edge after reset release
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (bus.op == OP_MUL) begin
                            r_mcand  <= {{WIDTH{1'b0}}, bus.a};
                            r_mplier <= bus.b;
                            r_acc    <= '0;
                            r_count  <= '0;
                            r_state  <= S_MUL;
                        end else begin
                            r_result    <= w_res;
                            r_flag_z    <= w_z;
                            r_flag_n    <= w_n;
                            r_flag_c    <= w_c;
                            r_flag_v    <= w_v;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end

                S_MUL: begin
                    if (r_count == CNT_LAST) begin
                        // All WIDTH steps done; this cycle only publishes.
                        r_result    <= r_acc[WIDTH-1:0];
                        r_flag_z    <= (r_acc[WIDTH-1:0] == '0);
                        r_flag_n    <= r_acc[WIDTH-1];
                        r_flag_c    <= |r_acc[2*WIDTH-1:WIDTH];
                        r_flag_v    <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_count  <= r_count + 1'b1;
                    end
                end

                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.flag_z    = r_flag_z;
    assign bus.flag_n    = r_flag_n;
    assign bus.flag_c    = r_flag_c;
    assign bus.flag_v    = r_flag_v;

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed self-checking bench for alu_seq at WIDTH=6.
//               Expected values are hand-computed in the vector calls.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int WIDTH = 6;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    alu_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v};
    endfunction

    // Present one operation and return just after its accepting edge.
    task automatic issue(input logic [2:0] op, input logic [5:0] a, input logic [5:0] b,
                         input string tag);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = 6'h2A;    // scramble: inputs must not matter now
        bus.b        = 6'h15;
        bus.op       = 3'd3;
    endtask

    // Count edges after the accepting edge until out_valid is seen (0 for
    // single-cycle ops whose result is registered at the accepting edge).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_ov_clr"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_rdy_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    // ef = {z, n, c, v}
    task automatic do_op(input string tag, input logic [2:0] op, input logic [5:0] a,
                         input logic [5:0] b, input logic [5:0] er, input logic [3:0] ef,
                         input int elat);
        int lat;
        issue(op, a, b, tag);
        wait_valid(lat);
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_res"}, 32'(bus.result), 32'(er));
        check({tag, "_flags"}, 32'(flags()), 32'(ef));
        drain(tag);
    endtask

    initial begin
        int lat;
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_flags", 32'(flags()), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);

        //     tag       op    a      b      res    zncv     lat
        do_op("add",    3'd0, 6'd44, 6'd34, 6'd14, 4'b0011, 0);
        do_op("sub1",   3'd1, 6'd3,  6'd2,  6'd1,  4'b0000, 0);
        do_op("sub0",   3'd1, 6'd20, 6'd20, 6'd0,  4'b1000, 0);
        do_op("subbor", 3'd1, 6'd2,  6'd3,  6'd63, 4'b0110, 0);
        do_op("or",     3'd3, 6'd33, 6'd6,  6'd39, 4'b0100, 0);
        do_op("shlbig", 3'd5, 6'd21, 6'd6,  6'd0,  4'b1000, 0);
        do_op("shl",    3'd5, 6'd21, 6'd1,  6'd42, 4'b0100, 0);
        do_op("shr",    3'd6, 6'd32, 6'd5,  6'd1,  4'b0000, 0);
        do_op("mulovf", 3'd7, 6'd10, 6'd8,  6'd16, 4'b0010, 7);
        do_op("mul",    3'd7, 6'd4,  6'd6,  6'd24, 4'b0000, 7);

        // Reset three cycles into a MUL: everything clears asynchronously.
        issue(3'd7, 6'd5, 6'd7, "rstmul");
        repeat (2) @(posedge clk);
        #1;
        check("mid_mul_ready", 32'(bus.in_ready), 32'd0);
        check("mid_mul_ov", 32'(bus.out_valid), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ov", 32'(bus.out_valid), 32'd0);
        check("abort_res", 32'(bus.result), 32'd0);
        check("abort_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_rel_ready", 32'(bus.in_ready), 32'd1);
        do_op("xor",    3'd4, 6'd10, 6'd21, 6'd31, 4'b0000, 0);

        // Backpressure: result must hold while out_ready stays low.
        issue(3'd2, 6'd12, 6'd32, "bp");
        wait_valid(lat);
        check("bp_lat", 32'(lat), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("bp_ov", 32'(bus.out_valid), 32'd1);
            check("bp_res", 32'(bus.result), 32'd0);
            check("bp_z", 32'(bus.flag_z), 32'd1);
            check("bp_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        drain("bp");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_alu_seq
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the 6-bit combinational ALU. It accepts one operation per valid/ready handshake and returns a registered result with status flags through a second valid/ready handshake. Opcodes 0-3 keep the 6-bit ALU encoding; the block adds XOR, shifts and a multi-cycle shift-add multiply. It sits between an operand issue stage and a result consumer.

Parameters:
WIDTH, 6, operand/result width in bits (>=2)
OPW, 3, opcode width (fixed at 3; exposed for the package)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands/opcode valid
in_ready  out  1  block can accept an operation
a  in  WIDTH  operand A
b  in  WIDTH  operand B
op  in  OPW  opcode
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
flag_z  out  1  result == 0
flag_n  out  1  result[WIDTH-1]
flag_c  out  1  carry/borrow/multiply-overflow
flag_v  out  1  signed overflow (ADD/SUB only)

Behaviour:
- Reset, asynchronous, rst_n=0: state=IDLE, in_ready=0 while rst_n low, out_valid=0, result=0, all flags 0, multiply registers cleared. in_ready=1 on the first cycle after release.
- Opcodes: 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 SHL a<<sh; 6 SHR a>>sh (logical); 7 MUL low WIDTH bits of a*b (unsigned).
- sh = b[clog2(WIDTH)-1:0]. If sh >= WIDTH, the result is 0.
- Flags:
  - ADD: c = carry-out; v = (a[msb]==b[msb]) && (res[msb]!=a[msb]).
  - SUB: c = borrow (a<b unsigned); v = (a[msb]!=b[msb]) && (res[msb]!=a[msb]).
  - MUL: c = 1 if any bit of the upper WIDTH product bits is nonzero; v=0.
  - Logic and shift ops: c=0, v=0.
  - z and n are always derived from the result.
- FSM states IDLE, MUL, DONE:
  - IDLE: in_ready=1. On in_valid && in_ready, a/b/op are captured. Op!=7: result and flags are computed and registered in the same edge, then go to DONE (latency 1 cycle to out_valid). Op=7: load multiplicand=a, multiplier=b, accumulator=0, count=0, then go to MUL.
  - MUL: one shift-add step per cycle, exactly WIDTH cycles. After the last step, register result/flags and go to DONE. out_valid rises WIDTH+1 cycles after the accepting edge. in_ready=0.
  - DONE: out_valid=1, in_ready=0. result and flags are held stable while out_ready=0 (unlimited backpressure). On out_ready=1, go to IDLE and deassert out_valid next cycle.
- Only one operation is in flight. Maximum throughput is one operation per 2 cycles for non-MUL ops.
- Inputs a/b/op are don't-care outside the accepting edge. Changes during MUL or DONE have no effect.
- in_valid during MUL or DONE is not accepted (in_ready=0). The upstream stage must hold it.
- Reset asserted mid-MUL or in DONE aborts immediately. The pending result is discarded and out_valid=0.
- All arithmetic is modulo 2^WIDTH. Operands are unsigned for c and two's complement for v/n.

Decomposition:
- Package alu_pkg: opcode localparams (OP_ADD..OP_MUL), state enum encoding (IDLE/MUL/DONE), and a shift-width function clog2.
- Sub-module alu_comb: purely combinational result + flag generation for opcodes 0-6.
- The FSM and shift-add multiplier stay in alu_seq.

Test Plan:
- WIDTH=6, ADD a=-20 (44), b=-30 (34) -> 1 cycle later out_valid=1, result=14, c=1, v=1, z=0, n=0.
- SUB a=3, b=2 -> result=1, c=0, v=0. SUB a=20, b=20 -> result=0, z=1, c=0.
- MUL a=10, b=8 -> out_valid exactly 7 cycles after accept, result=16, c=1. MUL a=4, b=6 -> result=24, c=0.
- SHL a=21, b=6 (sh=6>=WIDTH) -> result=0, z=1. SHR a=32, b=5 -> result=1.
- Backpressure: hold out_ready=0 for 5 cycles after AND a=12, b=32 -> result=0, z=1 held stable, in_ready=0 throughout. Pulse out_ready -> back to IDLE with in_ready=1.
- Reset mid-operation: assert rst_n=0 three cycles into a MUL -> out_valid=0, result=0 immediately. After release, XOR a=10, b=21 -> result=31, n=0.
